// File: rtl/gate_check_pkg.sv
// rtl/gate_check_pkg.sv - op encodings and FSM state type shared by the gate sweep checker
package gate_check_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_LAST = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/gate_golden_model.sv
// rtl/gate_golden_model.sv - combinational expected output of a two-input basic gate
module gate_golden_model
    import gate_check_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       q
);

    always_comb begin
        q = 1'b0;
        case (op)
            OP_AND:  q = a & b;
            OP_OR:   q = a | b;
            OP_XOR:  q = a ^ b;
            OP_NAND: q = ~(a & b);
            OP_NOR:  q = ~(a | b);
            OP_XNOR: q = ~(a ^ b);
            default: q = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - truth-table sweep of a two-input gate with golden compare
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             q_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             op_err,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(SETTLE_CYCLES);
    localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;
    logic             pass_q, pass_d;
    logic             op_err_q, op_err_d;
    logic             done_q, done_d;
    logic             golden_q;

    gate_golden_model u_golden (
        .op (op_q),
        .a  (idx_q[1]),
        .b  (idx_q[0]),
        .q  (golden_q)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pcnt_d   = pcnt_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        op_err_d = op_err_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d  = '0;
                    fail_d = '0;
                    pass_d = 1'b0;
                    cnt_d  = '0;
                    idx_d  = '0;
                    pcnt_d = '0;
                    if (op > OP_LAST) begin
                        op_err_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        op_err_d = 1'b0;
                        op_d     = op;
                        state_d  = APPLY;
                    end
                end
            end
            APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (q_in != golden_q) begin
                        fail_d[idx_q] = 1'b1;
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                    // idx wraps 3->0, which also parks a_out/b_out at 0 for DONE
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (pcnt_q == PASS_LAST) begin
                            pass_d  = (err_d == '0) && !op_err_q;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            pcnt_d = pcnt_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_AND;
            cnt_q    <= '0;
            idx_q    <= '0;
            pcnt_q   <= '0;
            err_q    <= '0;
            fail_q   <= '0;
            pass_q   <= 1'b0;
            op_err_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pcnt_q   <= pcnt_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
            op_err_q <= op_err_d;
            done_q   <= done_d;
        end
    end

    assign a_out     = idx_q[1];
    assign b_out     = idx_q[0];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign pass      = pass_q;
    assign op_err    = op_err_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - scoreboard bench with truth-table reference model
module tb_gate_sweep_checker;

    typedef struct {
        int         c1;
        int         done_cyc;
        bit         legal;
        bit         pass;
        bit         op_err;
        int         err;
        logic [3:0] fail;
    } exp_t;

    localparam int S0 = 4, P0 = 1, E0 = 8;
    localparam int S1 = 2, P1 = 3, E1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_s [2];
    logic [2:0] op_s    [2];
    logic [2:0] gut_s   [2];
    logic       q_s     [2];
    logic       a_s     [2];
    logic       b_s     [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic       pass_s  [2];
    logic       operr_s [2];
    logic [3:0] fv_s    [2];
    logic [7:0] ec0;
    logic [1:0] ec1;
    logic [3:0] tt0, tt1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    int verr[2];

    // truth table of each gate type, bit index = {a,b}; 6/7 model stuck-at faults
    function automatic logic [3:0] tt(input logic [2:0] f);
        case (f)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0110;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b0001;
            3'd5:    return 4'b1001;
            3'd6:    return 4'b0000;
            default: return 4'b1111;
        endcase
    endfunction

    assign tt0 = tt(gut_s[0]);
    assign tt1 = tt(gut_s[1]);
    assign q_s[0] = tt0[{a_s[0], b_s[0]}];
    assign q_s[1] = tt1[{a_s[1], b_s[1]}];

    gate_sweep_checker #(.SETTLE_CYCLES(S0), .PASSES(P0), .ERR_W(E0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op(op_s[0]), .q_in(q_s[0]),
        .a_out(a_s[0]), .b_out(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .op_err(operr_s[0]), .err_count(ec0), .fail_vec(fv_s[0])
    );

    gate_sweep_checker #(.SETTLE_CYCLES(S1), .PASSES(P1), .ERR_W(E1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op(op_s[1]), .q_in(q_s[1]),
        .a_out(a_s[1]), .b_out(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .op_err(operr_s[1]), .err_count(ec1), .fail_vec(fv_s[1])
    );

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // monitor: pops an expectation on every done pulse, tracks the vector sequence between
    exp_t me;
    bit   mhave;
    int   mec, ms;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mhave = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (mhave) me = (k == 0) ? q0[0] : q1[0];
            mec = (k == 0) ? int'(ec0) : int'(ec1);
            ms  = (k == 0) ? S0 : S1;
            if (rst_n && done_s[k]) begin
                if (!mhave) begin
                    chk("unexpected_done", k, 1, 0);
                end else begin
                    if (k == 0) me = q0.pop_front(); else me = q1.pop_front();
                    chk("done_cycle", k, cyc, me.done_cyc);
                    chk("pass", k, int'(pass_s[k]), int'(me.pass));
                    chk("op_err", k, int'(operr_s[k]), int'(me.op_err));
                    chk("err_count", k, mec, me.err);
                    chk("fail_vec", k, int'(fv_s[k]), int'(me.fail));
                    chk("busy_at_done", k, int'(busy_s[k]), 1);
                    chk("ab_at_done", k, int'({a_s[k], b_s[k]}), 0);
                    chk("vector_seq_errs", k, verr[k], 0);
                    verr[k] = 0;
                end
            end else if (rst_n && mhave && me.legal && cyc >= me.c1) begin
                if (int'({a_s[k], b_s[k]}) != ((cyc - me.c1) / (ms + 1)) % 4 || !busy_s[k])
                    verr[k]++;
            end else if (rst_n && !mhave && busy_s[k]) begin
                chk("unexpected_busy", k, 1, 0);
            end
        end
    end

    // called at a negedge; start is sampled on the next posedge (t0)
    task automatic launch(input int k, input logic [2:0] op, input logic [2:0] gut);
        exp_t e;
        logic [3:0] m;
        int s, p, emax, n;
        s    = (k == 0) ? S0 : S1;
        p    = (k == 0) ? P0 : P1;
        emax = (k == 0) ? (1 << E0) - 1 : (1 << E1) - 1;
        gut_s[k]   = gut;
        op_s[k]    = op;
        start_s[k] = 1'b1;
        e.c1    = cyc + 1;
        e.legal = (op <= 3'd5);
        if (e.legal) begin
            m          = tt(op) ^ tt(gut);
            n          = p * $countones(m);
            e.err      = (n > emax) ? emax : n;
            e.fail     = m;
            e.pass     = (n == 0);
            e.op_err   = 1'b0;
            e.done_cyc = cyc + 4 * p * (s + 1) + 1;
        end else begin
            e.err      = 0;
            e.fail     = 4'b0000;
            e.pass     = 1'b0;
            e.op_err   = 1'b1;
            e.done_cyc = cyc + 1;
        end
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        while (((k == 0) ? q0.size() : q1.size()) != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            chk("run_timeout", k, t, 0);
            if (k == 0) q0.delete(); else q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input int k);
        chk("rst_ab", k, int'({a_s[k], b_s[k]}), 0);
        chk("rst_busy_done", k, int'({busy_s[k], done_s[k]}), 0);
        chk("rst_pass_operr", k, int'({pass_s[k], operr_s[k]}), 0);
        chk("rst_err_count", k, (k == 0) ? int'(ec0) : int'(ec1), 0);
        chk("rst_fail_vec", k, int'(fv_s[k]), 0);
    endtask

    initial begin
        int x0, k;
        logic [2:0] rop, rgut;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            op_s[i]    = 3'd0;
            gut_s[i]   = 3'd0;
            verr[i]    = 0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state(0);
        chk_reset_state(1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        launch(0, 3'd0, 3'd0);   // AND gate, AND expected
        wait_idle(0);
        launch(0, 3'd0, 3'd1);   // OR gate, AND expected
        wait_idle(0);
        launch(0, 3'd6, 3'd0);   // illegal op
        wait_idle(0);
        launch(1, 3'd0, 3'd3);   // NAND gate, 3 passes, saturating counter
        wait_idle(1);

        // reset during vector 2 after a mismatch has been recorded
        x0 = cyc;
        launch(0, 3'd0, 3'd1);
        while (cyc < x0 + 12) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        verr[0] = 0;
        #1;
        chk_reset_state(0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        launch(0, 3'd0, 3'd0);
        wait_idle(0);

        // starts in cycles 3 and 21 are ignored, cycle 22 is accepted
        x0 = cyc;
        launch(0, 3'd2, 3'd2);
        while (cyc < x0 + 3) @(negedge clk);
        start_s[0] = 1'b1;
        op_s[0]    = 3'd4;
        @(negedge clk);
        start_s[0] = 1'b0;
        op_s[0]    = 3'd2;
        while (cyc < x0 + 21) @(negedge clk);
        start_s[0] = 1'b1;
        op_s[0]    = 3'd1;
        @(negedge clk);
        launch(0, 3'd0, 3'd0);
        wait_idle(0);

        for (int i = 0; i < 24; i++) begin
            k    = int'($urandom_range(0, 1));
            rop  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            rgut = 3'($urandom_range(0, 7));
            launch(k, rop, rgut);
            wait_idle(k);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking truth-table sweeper for two-input basic gates. It drives the four input vectors into a gate under test, waits a programmable settle time, samples the gate output and compares it against a built-in golden model. It reports per-vector failures, an error count and pass/fail. It sits beside the basic gate designs as the in-fabric response-checking end of the stimulus/response flow, so a gate can be verified on hardware without a simulator.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles each vector is held before sampling (≥1).
- PASSES, default 1: number of full 4-vector sweeps per run (≥1).
- ERR_W, default 8: width of error counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request, sampled only in IDLE.
- op  in  3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6–7 illegal.
- q_in  in  1  output of gate under test.
- a_out  out  1  A input to gate under test.
- b_out  out  1  B input to gate under test.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  run result. Valid from done until the next accepted start.
- op_err  out  1  last start carried an illegal op.
- err_count  out  ERR_W  mismatches in last run, saturating.
- fail_vec  out  4  sticky bit per vector index that mismatched in any pass.

## Operation
- Reset (async, rst_n=0) clears all state and outputs immediately:
  - a_out=0, b_out=0, busy=0, done=0, pass=0, op_err=0, err_count=0, fail_vec=0.
  - FSM goes to IDLE.
- States:
  - IDLE → APPLY on start with legal op.
  - IDLE → DONE on start with illegal op.
  - APPLY → APPLY while vectors remain.
  - APPLY → DONE after the last sample of the last pass.
  - DONE → IDLE unconditionally.
- Accepted start (legal op):
  - Latch op.
  - Clear err_count, fail_vec, pass, op_err.
  - Set vector index idx=0 and pass counter=0.
- Vector mapping: a_out=idx[1], b_out=idx[0]. Order is 00, 01, 10, 11.
- APPLY:
  - A settle counter runs 0..SETTLE_CYCLES.
  - On the edge where counter==SETTLE_CYCLES, sample q_in and compare with golden(op, a_out, b_out).
  - On mismatch: err_count increments, saturating at 2^ERR_W−1, and fail_vec[idx] is set.
  - Then idx advances and wraps 3→0. When it wraps, the pass counter increments.
- DONE:
  - done=1 for exactly one cycle.
  - pass=(err_count==0 after final compare) and !op_err.
  - a_out and b_out return to 0.
- Illegal op start: no vectors are driven. err_count and fail_vec are cleared, op_err=1, pass=0, and the FSM enters DONE on the next edge.
- start while busy or in DONE is ignored. It is not queued.
- op changes during a run have no effect, because op is latched.

## Timing
- Start is accepted on edge t0. Vector 0 is on a_out/b_out from t0 onward, registered.
- Each vector is held SETTLE_CYCLES+1 cycles. q_in is sampled on the last edge of that window.
- A run lasts 4·PASSES·(SETTLE_CYCLES+1) cycles in APPLY, then one DONE cycle.
- With defaults, done is high during cycle 21 after t0 (cycles numbered 1 from t0).
- busy=1 from t0 through the DONE cycle inclusive. It is 0 in IDLE.
- Illegal op: done is high the cycle after t0, busy is high for that cycle only.
- Result outputs (pass, err_count, fail_vec, op_err) hold until the next accepted start or reset.
- Reset asserted mid-run aborts the run with no done pulse.

## Structure
- Shared package gate_check_pkg:
  - op encoding constants (OP_AND … OP_XNOR), and OP_LAST=5 for the legality check.
  - FSM state type {IDLE, APPLY, DONE}.
- Sub-module gate_golden_model: combinational (op, a, b) → expected q. It uses the package constants and outputs 0 for illegal op.
- Top level holds the FSM, settle counter, vector/pass counters and result registers.

## Test plan
- AND gate DUT, op=0, defaults, start pulse:
  - vectors 00, 01, 10, 11, each held 5 cycles;
  - done in cycle 21;
  - pass=1, err_count=0, fail_vec=0000.
- OR gate DUT, op=0 (AND expected): err_count=2, fail_vec=0110, pass=0.
- op=6 with start: op_err=1, done the cycle after start, pass=0, a_out/b_out stay 0, err_count=0.
- rst_n low during vector 2 of a run:
  - all outputs go to reset values immediately, with no done;
  - a following start with the AND DUT gives a clean pass=1.
- PASSES=3, ERR_W=2, NAND DUT, op=0: 12 mismatches, err_count saturates at 3, fail_vec=1111, pass=0.
- start pulsed at cycles 3 and 21 of a default run: ignored. A start in the cycle after done is accepted and launches a new run.
